tone_sequencer: RTL and testbench
=================================

# tone_sequencer

Parametrised, table-driven buzzer sequencer for the Cyclone IV board. Generalises the fixed-tune player into a reusable block: the song lives in a writable note RAM and plays on a start pulse, with a configurable repeat count, a pause input and a done flag. An optional multiplexed 7-segment readout shows the current repeat and note index. It sits between the board buttons/LED logic and the piezo pin.

## Interface
- `DEPTH`, 64: note RAM entries, 2..256; `AW = $clog2(DEPTH)`.
- `TONE_W`, 17: half-period field width, in clk cycles.
- `BEAT_CYCLES`, 10000000: clk cycles per beat, ≥1.
- `REPEATS`, 2: number of song passes per start, 1..15.
- `SCAN_BITS`, 16: display digit dwell is 2^SCAN_BITS cycles.
- `clk` in 1: sole clock, rising edge.
- `rb` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle start request.
- `pause` in 1: level input; high freezes playback.
- `wr_en` in 1: note RAM write strobe.
- `wr_addr` in AW: write address.
- `wr_data` in TONE_W+3: `{silence, len[1:0], half_period[TONE_W-1:0]}`.
- `buzzer` out 1: piezo drive; 1 = quiet.
- `busy` out 1: high from the accepted start until done.
- `done` out 1: one-cycle pulse at the end of the last pass.
- `note_idx` out AW: index of the entry currently playing.
- `segs` out 8: active-low segments, bit7 = a … bit1 = g, bit0 = dp.
- `bits` out 4: active-low digit select, bit3 = leftmost digit.

## Operation
- The entry `len` field sets duration: 0 = 1 beat, 1 = 2 beats, 2 = 4 beats, 3 = end-of-song marker. The marker plays nothing and takes 0 beats.
- An entry is silent if `silence` = 1 or `half_period` = 0.
- States:
  - IDLE: `busy` = 0, `buzzer` = 1. On `start`: idx = 0, rep = 0, go to FETCH.
  - FETCH: one cycle, registered RAM read of entry[idx]. Go to PLAY, or to WRAP if the entry is the marker.
  - PLAY: the beat counter runs for `beats*BEAT_CYCLES` cycles.
    - Tone counter counts 1..half_period. On a match, `buzzer` toggles and the counter returns to 0.
    - `buzzer` is 0 at the first PLAY cycle of a tone entry. It is held at 1 for a silent entry.
    - At the terminal count: if idx = DEPTH-1, go to WRAP; otherwise idx++ and go to FETCH.
  - WRAP: if rep < REPEATS-1, then rep++, idx = 0, go to FETCH. Otherwise go to IDLE with `done` = 1 for one cycle.
- `pause` high in PLAY:
  - beat and tone counters hold.
  - `buzzer` is forced to 1.
  - on release, `buzzer` resumes its pre-pause level.
  - `pause` has no effect in other states.
- `start` while `busy` is ignored.
- `wr_en` while `busy` is ignored; the RAM is writable in IDLE only.
- The beat counter is `$clog2(4*BEAT_CYCLES+1)` bits wide. The tone counter is TONE_W bits. No counter wraps within a legal note.

## Timing
- Reset values: `buzzer` = 1, `busy` = 0, `done` = 0, `note_idx` = 0, state IDLE, rep = 0. With display enabled, `segs` = 8'hFF and `bits` = 4'b0111.
- Reset applies mid-song with the same values on the next edge. RAM contents are not cleared by reset and are undefined at power-up.
- `start` sampled in cycle N: `busy` = 1 in N+1 (FETCH), first PLAY cycle in N+2.
- Each non-marker entry costs exactly 1 + `beats*BEAT_CYCLES` cycles. A marker costs 1 FETCH cycle. Each WRAP costs 1 cycle.
- `done` rises in the cycle `busy` falls. `start` in that same cycle is ignored; `start` in the next cycle is accepted.
- `note_idx` updates in the FETCH cycle of the new entry.
- Write takes effect at the edge: entry written in cycle N is readable by a FETCH in N+1.

## Configuration
- `TONE_SEQUENCER_DISPLAY_EN` defined: 4-digit scan, advancing one digit every 2^SCAN_BITS cycles in order bits3→bits0.
  - digit3 = rep+1 in hex.
  - digit2 blank (8'hFF).
  - digits1..0 = `note_idx` in hex, zero-extended to 8 bits.
  - In IDLE, all digits show "-" (8'b11111101).
- Undefined: no scan logic; `segs` is tied to 8'hFF and `bits` to 4'hF.

## Test plan
- Bench setup for all scenarios: BEAT_CYCLES = 8, DEPTH = 4, REPEATS = 2, SCAN_BITS = 2.
- Load {0,0,3},{1,0,0},{0,1,2},{0,3,0}, then pulse `start` → `busy` for 2×(9+9+17+1)+2 = 74 cycles then `done` pulse. Buzzer toggles every 3 cycles in entry 0 and every 2 in entry 2, holds 1 in entry 1.
- Load with no marker, all entries `len` = 0 → idx runs 0..3, WRAP after idx 3, and `done` follows the second pass.
- `pause` held for 5 cycles mid entry 0 → `buzzer` = 1 throughout the pause, and the song ends exactly 5 cycles later than the unpaused run.
- `rb` asserted during entry 2 of pass 1 → next cycle `buzzer` = 1, `busy` = 0, `note_idx` = 0. A `start` in the following cycle restarts from entry 0.
- `wr_en` and `start` asserted while `busy` → RAM unchanged (verified by a replay) and no restart.
- Display enabled: during pass 2, entry 2 → `bits` cycles 0111, 1011, 1101, 1110 every 4 cycles. `segs` shows 2 (8'b00100101), blank, 0, 2.

Source files
------------

// File: rtl/tone_sequencer.sv
// tone_sequencer: table-driven piezo sequencer.
// A note RAM (writable only while idle) holds {silence, len, half_period}
// entries; a start pulse plays the table REPEATS times, then pulses done.
// Optional build macro TONE_SEQUENCER_DISPLAY_EN adds a 4-digit multiplexed
// 7-segment readout of pass number and note index; without it segs/bits are
// tied inactive.
module tone_sequencer #(
  parameter  int DEPTH       = 64,
  parameter  int TONE_W      = 17,
  parameter  int BEAT_CYCLES = 10000000,
  parameter  int REPEATS     = 2,
  parameter  int SCAN_BITS   = 16,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rb,
  input  logic              start,
  input  logic              pause,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [TONE_W+2:0] wr_data,
  output logic              buzzer,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     note_idx,
  output logic [7:0]        segs,
  output logic [3:0]        bits
);

  // Beat counter must hold up to 4 beats worth of cycles.
  localparam int BW = $clog2(4*BEAT_CYCLES+1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);
  localparam logic [3:0]    REP_LAST = 4'(REPEATS-1);
  localparam logic [1:0]    LEN_END  = 2'd3;

  typedef struct packed {
    logic              silence;
    logic [1:0]        len;
    logic [TONE_W-1:0] hp;
  } note_t;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, WRAP} state_t;

  // Last cycle index of a note, by len code (marker never reaches PLAY).
  function automatic logic [BW-1:0] beat_lim(input logic [1:0] len);
    case (len)
      2'd0:    return BW'(BEAT_CYCLES-1);
      2'd1:    return BW'(2*BEAT_CYCLES-1);
      default: return BW'(4*BEAT_CYCLES-1);
    endcase
  endfunction

  note_t             ram [DEPTH];
  note_t             fe;
  state_t            state;
  logic [3:0]        rep;
  logic [BW-1:0]     bcnt, blim;
  logic [TONE_W-1:0] tcnt, tnext, hp;
  logic              sil, lvl;

  assign fe    = ram[note_idx];
  assign tnext = tcnt + 1'b1;

  // Note RAM: written only while idle, no reset (contents survive rb).
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) ram[wr_addr] <= note_t'(wr_data);
  end

  // Sequencer FSM: fetch/play/wrap over the table, tone and beat counters.
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rb) begin
      state    <= IDLE;
      busy     <= 1'b0;
      lvl      <= 1'b1;
      note_idx <= '0;
      rep      <= '0;
      bcnt     <= '0;
      blim     <= '0;
      tcnt     <= '0;
      hp       <= '0;
      sil      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // done is high in the cycle right after the last pass; a start
          // landing there is dropped so the host sees a clean gap.
          if (start && !done) begin
            note_idx <= '0;
            rep      <= '0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          bcnt  <= '0;
          tcnt  <= '0;
          hp    <= fe.hp;
          blim  <= beat_lim(fe.len);
          sil   <= fe.silence || (fe.hp == '0);
          // Tone entries start low; silent entries and the marker stay quiet.
          lvl   <= (fe.len == LEN_END) || fe.silence || (fe.hp == '0);
          state <= (fe.len == LEN_END) ? WRAP : PLAY;
        end
        PLAY: begin
          if (!pause) begin
            if (!sil) begin
              if (tnext == hp) begin
                lvl  <= ~lvl;
                tcnt <= '0;
              end else begin
                tcnt <= tnext;
              end
            end
            if (bcnt == blim) begin
              lvl <= 1'b1;
              if (note_idx == LAST_IDX) begin
                state <= WRAP;
              end else begin
                note_idx <= note_idx + 1'b1;
                state    <= FETCH;
              end
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        WRAP: begin
          if (rep < REP_LAST) begin
            rep      <= rep + 1'b1;
            note_idx <= '0;
            state    <= FETCH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pause silences the pin immediately; lvl keeps the pre-pause phase.
  assign buzzer = lvl | (pause && state == PLAY);

`ifdef TONE_SEQUENCER_DISPLAY_EN
  localparam logic [7:0] SEG_DASH  = 8'b11111101;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [SCAN_BITS+1:0] scan;
  logic [1:0]           dsel;
  logic [7:0]           idx8;

  assign dsel = scan[SCAN_BITS+1:SCAN_BITS];
  assign idx8 = 8'(note_idx);

  // Active-low hex font, {a,b,c,d,e,f,g,dp}.
  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 8'b00000011;
      4'h1: return 8'b10011111;
      4'h2: return 8'b00100101;
      4'h3: return 8'b00001101;
      4'h4: return 8'b10011001;
      4'h5: return 8'b01001001;
      4'h6: return 8'b01000001;
      4'h7: return 8'b00011111;
      4'h8: return 8'b00000001;
      4'h9: return 8'b00001001;
      4'hA: return 8'b00010001;
      4'hB: return 8'b11000001;
      4'hC: return 8'b01100011;
      4'hD: return 8'b10000101;
      4'hE: return 8'b01100001;
      default: return 8'b01110001;
    endcase
  endfunction

  // Digit scan: leftmost digit first, one digit per 2^SCAN_BITS cycles.
  always_ff @(posedge clk) begin
    if (rb) begin
      scan <= '0;
      segs <= SEG_BLANK;
      bits <= 4'b0111;
    end else begin
      scan <= scan + 1'b1;
      bits <= ~(4'b1000 >> dsel);
      if (state == IDLE) begin
        segs <= SEG_DASH;
      end else begin
        case (dsel)
          2'd0:    segs <= hex7(rep + 4'd1);
          2'd1:    segs <= SEG_BLANK;
          2'd2:    segs <= hex7(idx8[7:4]);
          default: segs <= hex7(idx8[3:0]);
        endcase
      end
    end
  end
`else
  assign segs = 8'hFF;
  assign bits = 4'hF;
`endif

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: a per-cycle expected trace is built
// from the note table at song start and consumed by a monitor whenever the
// DUT reports busy or done.
module tb_tone_sequencer;
  localparam int DEPTH = 4, TONE_W = 17, BC = 8, REPEATS = 2, SCAN_BITS = 2;
  localparam int AW = 2, DW = TONE_W + 3;

  logic clk = 1'b0, rb = 1'b1, start = 1'b0, pause = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic buzzer, busy, done;
  logic [AW-1:0] note_idx;
  logic [7:0] segs;
  logic [3:0] bits;

  tone_sequencer #(.DEPTH(DEPTH), .TONE_W(TONE_W), .BEAT_CYCLES(BC),
                   .REPEATS(REPEATS), .SCAN_BITS(SCAN_BITS)) dut (
    .clk(clk), .rb(rb), .start(start), .pause(pause), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .buzzer(buzzer), .busy(busy),
    .done(done), .note_idx(note_idx), .segs(segs), .bits(bits));

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy; logic done; logic buz; logic [AW-1:0] idx; logic chk_idx;
  } exp_t;

  exp_t q[$];
  logic [DW-1:0] mem [DEPTH];
  int total = 0, bad = 0, busy_cyc = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic z, input int i, input logic ci);
    exp_t r;
    r.busy = b; r.done = d; r.buz = z; r.idx = AW'(i); r.chk_idx = ci;
    return r;
  endfunction

  function automatic logic [DW-1:0] ent(input logic s, input logic [1:0] l, input int hp);
    return {s, l, TONE_W'(hp)};
  endfunction

  // Reference: walk the table pass by pass; optional pause of pl cycles
  // before play cycle pk of entry 0 in the first pass.
  task automatic push_song(input int pk, input int pl);
    int last, len, hp;
    logic sil, z;
    for (int p = 0; p < REPEATS; p++) begin
      last = DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) begin
        hp  = int'(mem[i][TONE_W-1:0]);
        len = int'(mem[i][TONE_W+1:TONE_W]);
        sil = mem[i][TONE_W+2] || (hp == 0);
        q.push_back(mk(1'b1, 1'b0, 1'b1, i, 1'b1));
        if (len == 3) begin
          last = i;
          break;
        end
        for (int k = 0; k < (BC << len); k++) begin
          if (p == 0 && i == 0 && k == pk)
            repeat (pl) q.push_back(mk(1'b1, 1'b0, 1'b1, i, 1'b1));
          z = sil ? 1'b1 : (((k / (sil ? 1 : hp)) % 2) == 1);
          q.push_back(mk(1'b1, 1'b0, z, i, 1'b1));
        end
      end
      q.push_back(mk(1'b1, 1'b0, 1'b1, last, 1'b0));
    end
    q.push_back(mk(1'b0, 1'b1, 1'b1, 0, 1'b0));
  endtask

  // Monitor: one trace record per cycle the DUT shows busy or done.
  always @(negedge clk) begin
    exp_t r;
    if (busy) busy_cyc++;
    if (mon_en && (busy || done)) begin
      if (q.size() == 0) begin
        chk("unexpected_activity", 32'({busy, done}), 32'd0);
      end else begin
        r = q.pop_front();
        chk("trace_busy_done_buzzer", 32'({busy, done, buzzer}), 32'({r.busy, r.done, r.buz}));
        if (r.chk_idx) chk("trace_note_idx", 32'(note_idx), 32'(r.idx));
      end
    end
  end

  task automatic wr_ent(input int i, input logic [DW-1:0] d);
    @(posedge clk); #1 wr_en = 1'b1; wr_addr = AW'(i); wr_data = d; mem[i] = d;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic load_song_a();
    wr_ent(0, ent(1'b0, 2'd0, 3));
    wr_ent(1, ent(1'b1, 2'd0, 0));
    wr_ent(2, ent(1'b0, 2'd1, 2));
    wr_ent(3, ent(1'b0, 2'd3, 0));
  endtask

  // Start from idle; returns 1ns after the edge that sampled start.
  task automatic kick(input int pk, input int pl);
    @(posedge clk); #1 start = 1'b1; push_song(pk, pl);
    @(posedge clk); #1 start = 1'b0;
    if (pl > 0) begin
      repeat (1 + pk) @(posedge clk);
      #1 pause = 1'b1;
      repeat (pl) @(posedge clk);
      #1 pause = 1'b0;
    end
  endtask

  // Returns 1ns after the negedge of the done cycle.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    #1;
    chk("done_seen", 32'(seen), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bsamp [16];
    int pk, pl;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_buzzer", 32'(buzzer), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_note_idx", 32'(note_idx), 32'd0);
`ifdef TONE_SEQUENCER_DISPLAY_EN
    chk("rst_segs", 32'(segs), 32'hFF);
    chk("rst_bits", 32'(bits), 32'b0111);
`else
    chk("rst_segs", 32'(segs), 32'hFF);
    chk("rst_bits", 32'(bits), 32'hF);
`endif
    @(posedge clk); #1 rb = 1'b0; pause = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pause_buzzer", 32'(buzzer), 32'd1);
    chk("idle_pause_busy", 32'(busy), 32'd0);
`ifdef TONE_SEQUENCER_DISPLAY_EN
    chk("idle_dash", 32'(segs), 32'b11111101);
`endif
    #1 pause = 1'b0;

    // Reference tune with end marker.
    load_song_a();
    busy_cyc = 0;
    kick(0, 0);
    wait_done();
    chk("song_a_busy_len", 32'(busy_cyc), 32'd74);

    // Same tune, 5-cycle pause inside entry 0.
    busy_cyc = 0;
    kick(4, 5);
    wait_done();
    chk("pause_busy_len", 32'(busy_cyc), 32'd79);

`ifdef TONE_SEQUENCER_DISPLAY_EN
    // Readout during pass 2, entry 2 (trace records 56..71).
    kick(0, 0);
    repeat (57) @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      bsamp[j] = bits;
      case (bits)
        4'b0111: chk("disp_rep_digit", 32'(segs), 32'b00100101);
        4'b1011: chk("disp_blank", 32'(segs), 32'hFF);
        4'b1101: chk("disp_idx_hi", 32'(segs), 32'b00000011);
        4'b1110: chk("disp_idx_lo", 32'(segs), 32'b00100101);
        default: chk("disp_bits_onehot", 32'(bits), 32'b0111);
      endcase
    end
    for (int j = 0; j < 12; j++)
      chk("disp_scan_order", 32'(bsamp[j+4]), 32'({bsamp[j][0], bsamp[j][3:1]}));
    wait_done();
`endif

    // No marker, all one-beat entries: full wrap at idx 3.
    for (int i = 0; i < DEPTH; i++)
      wr_ent(i, ent(1'($urandom_range(0, 3) == 0), 2'd0, int'($urandom_range(1, 6))));
    busy_cyc = 0;
    kick(0, 0);
    wait_done();
    chk("nomarker_busy_len", 32'(busy_cyc), 32'd74);

    // Random tables, occasional pause in entry 0.
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < DEPTH; i++)
        wr_ent(i, ent(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 6))));
      pl = 0;
      pk = 0;
      if (mem[0][TONE_W+1:TONE_W] != 2'd3 && $urandom_range(0, 1) == 1) begin
        pk = int'($urandom_range(0, BC - 1));
        pl = int'($urandom_range(1, 6));
      end
      kick(pk, pl);
      wait_done();
    end

    // Writes and start while busy are dropped; start in the done cycle is
    // dropped, start one cycle later is taken; replay proves RAM intact.
    load_song_a();
    kick(0, 0);
    repeat (10) @(posedge clk);
    #1 wr_en = 1'b1; wr_addr = '0; wr_data = ~mem[0]; start = 1'b1;
    @(posedge clk); #1 wr_en = 1'b0; start = 1'b0;
    wait_done();
    busy_cyc = 0;
    start = 1'b1;
    push_song(0, 0);
    @(negedge clk);
    chk("start_in_done_cycle_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    chk("replay_busy_len", 32'(busy_cyc), 32'd74);

    // Reset during entry 2 of pass 1, then immediate restart.
    kick(0, 0);
    repeat (23) @(posedge clk);
    #1 mon_en = 1'b0; rb = 1'b1;
    @(posedge clk); #1 rb = 1'b0; start = 1'b1;
    q.delete();
    push_song(0, 0);
    @(negedge clk);
    chk("midrst_buzzer", 32'(buzzer), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_note_idx", 32'(note_idx), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    mon_en = 1'b1;
    busy_cyc = 0;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    chk("restart_busy_len", 32'(busy_cyc), 32'd74);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
